// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style control unit: Moore FSM sequencing fetch, decode,
// memory, R-type, branch, addi and jump steps and driving datapath strobes.
// Optional build macro MULT_STALL_EN: holds RTEXEC for MULT_CYCLES cycles on mult.
module multi_cycle_control #(
  parameter int unsigned MULT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StRtExec = 4'd6,
    StRtWb   = 4'd7,
    StBeq    = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

  localparam logic [5:0] OpLw     = 6'b100011;
  localparam logic [5:0] OpSw     = 6'b101011;
  localparam logic [5:0] OpRtype  = 6'b000000;
  localparam logic [5:0] OpBeq    = 6'b000100;
  localparam logic [5:0] OpAddi   = 6'b001000;
  localparam logic [5:0] OpJ      = 6'b000010;
  localparam logic [5:0] FnMult   = 6'b011000;

  // Reject out-of-range stall lengths at elaboration time.
  if (MULT_CYCLES < 1 || MULT_CYCLES > 8) begin : g_bad_mult_cycles
    $error("MULT_CYCLES must be in 1..8");
  end

  state_e state;

`ifdef MULT_STALL_EN
  localparam logic [2:0] MultLoad = 3'(MULT_CYCLES - 1);
  logic [2:0] mult_cnt;
`endif

  // State register and next-state sequencing; reset abandons any instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= StFetch;
`ifdef MULT_STALL_EN
      mult_cnt <= '0;
`endif
    end else begin
      unique case (state)
        StFetch:  if (MemReady) state <= StDecode;
        StDecode: begin
          case (Opcode)
            OpLw, OpSw: state <= StMemAdr;
            OpRtype: begin
              state <= StRtExec;
`ifdef MULT_STALL_EN
              // Counter holds the remaining extra RTEXEC cycles for mult.
              mult_cnt <= (Funct == FnMult) ? MultLoad : 3'd0;
`endif
            end
            OpBeq:  state <= StBeq;
            OpAddi: state <= StAddiEx;
            OpJ:    state <= StJump;
            default: state <= StFetch;
          endcase
        end
        StMemAdr: state <= (Opcode == OpSw) ? StMemWr : StMemRd;
        StMemRd:  if (MemReady) state <= StMemWb;
        StMemWb:  state <= StFetch;
        StMemWr:  if (MemReady) state <= StFetch;
        StRtExec: begin
`ifdef MULT_STALL_EN
          if (mult_cnt != 3'd0) mult_cnt <= mult_cnt - 3'd1;
          else                  state    <= StRtWb;
`else
          state <= StRtWb;
`endif
        end
        StRtWb:   state <= StFetch;
        StBeq:    state <= StFetch;
        StAddiEx: state <= StAddiWb;
        StAddiWb: state <= StFetch;
        StJump:   state <= StFetch;
        default:  state <= StFetch;
      endcase
    end
  end

  // Moore output decode; FETCH strobes follow MemReady, reset forces all zero.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 4'b0000;
    PCSource    = 2'b00;
    case (state)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = 4'b0010;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      StDecode: begin
        ALUSrcB = 2'b11;
        ALUOp   = 4'b0010;
      end
      StMemAdr, StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 4'b0010;
      end
      StMemRd: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      StMemWb: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
      end
      StMemWr: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      StRtExec: begin
        ALUSrcA = 1'b1;
        case (Funct)
          6'b100000: ALUOp = 4'b0010;
          6'b100010: ALUOp = 4'b0110;
          6'b100100: ALUOp = 4'b0000;
          6'b100101: ALUOp = 4'b0001;
          6'b101010: ALUOp = 4'b0111;
          6'b011000: ALUOp = 4'b1000;
          6'b100110: ALUOp = 4'b1101;
          6'b100111: ALUOp = 4'b1100;
          default:   ALUOp = 4'b0000;
        endcase
      end
      StRtWb: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      StBeq: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 4'b0110;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      StAddiWb: RegWrite = 1'b1;
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemToReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 4'b0000;
      PCSource    = 2'b00;
    end
  end

  assign State = state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: per-instruction expected state
// traces built from instruction class and memory wait counts, plus directed cases.
module tb_multi_cycle_control;

  localparam int unsigned MC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode, Funct;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemToReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUOp, State;

  multi_cycle_control #(.MULT_CYCLES(MC)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .State(State)
  );

  always #5 clk = ~clk;

  logic [17:0] outs;
  assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                 RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] alu_of_funct(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b0010;  // add
      6'b100010: return 4'b0110;  // sub
      6'b100100: return 4'b0000;  // and
      6'b100101: return 4'b0001;  // or
      6'b101010: return 4'b0111;  // slt
      6'b011000: return 4'b1000;  // mult
      6'b100110: return 4'b1101;  // xor
      6'b100111: return 4'b1100;  // nor
      default:   return 4'b0000;
    endcase
  endfunction

  // Expected output bundle for a state, written straight from the state table.
  function automatic logic [17:0] exp_outs(input int st, input logic [5:0] f, input logic mr);
    logic pcw = 0, pcc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0;
    logic rw = 0, sa = 0;
    logic [1:0] sb = 0, pcs = 0;
    logic [3:0] op = 0;
    case (st)
      0:  begin mrd = 1; sb = 2'b01; op = 4'b0010; irw = mr; pcw = mr; end
      1:  begin sb = 2'b11; op = 4'b0010; end
      2:  begin sa = 1; sb = 2'b10; op = 4'b0010; end
      3:  begin iord = 1; mrd = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mwr = 1; end
      6:  begin sa = 1; op = alu_of_funct(f); end
      7:  begin rdst = 1; rw = 1; end
      8:  begin sa = 1; op = 4'b0110; pcc = 1; pcs = 2'b01; end
      9:  begin sa = 1; sb = 2'b10; op = 4'b0010; end
      10: rw = 1;
      11: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, op, pcs};
  endfunction

  typedef struct {
    logic [3:0] st;
    logic       mr;
  } step_t;

  step_t plan[$];

  task automatic add_step(input int st, input logic mr);
    step_t s;
    s.st = 4'(st);
    s.mr = mr;
    plan.push_back(s);
  endtask

  // Expected state trace of one instruction from its class and memory waits.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    plan.delete();
    for (int i = 0; i < fw; i++) add_step(0, 1'b0);
    add_step(0, 1'b1);
    add_step(1, 1'($urandom_range(0, 1)));
    case (op)
      6'b100011: begin
        add_step(2, 1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) add_step(3, 1'b0);
        add_step(3, 1'b1);
        add_step(4, 1'($urandom_range(0, 1)));
      end
      6'b101011: begin
        add_step(2, 1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) add_step(5, 1'b0);
        add_step(5, 1'b1);
      end
      6'b000000: begin
        int n = 1;
`ifdef MULT_STALL_EN
        if (fn == 6'b011000) n = MC;
`endif
        for (int i = 0; i < n; i++) add_step(6, 1'($urandom_range(0, 1)));
        add_step(7, 1'($urandom_range(0, 1)));
      end
      6'b000100: add_step(8, 1'($urandom_range(0, 1)));
      6'b001000: begin
        add_step(9, 1'($urandom_range(0, 1)));
        add_step(10, 1'($urandom_range(0, 1)));
      end
      6'b000010: add_step(11, 1'($urandom_range(0, 1)));
      default: ;
    endcase
  endtask

  // Drives each planned cycle just after the rising edge, checks at the falling edge.
  task automatic run_plan(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input int exp_rw);
    int rw_cnt = 0;
    bit first = 1;
    while (plan.size() > 0) begin
      step_t s = plan.pop_front();
      @(posedge clk);
      #1;
      if (first) begin
        Opcode = op;
        Funct  = fn;
        first  = 0;
      end
      MemReady = s.mr;
      @(negedge clk);
      check_eq({name, " state"}, 32'(State), 32'(s.st));
      check_eq({name, " outs"}, 32'(outs), 32'(exp_outs(int'(s.st), fn, s.mr)));
      check_eq({name, " rd_and_wr"}, 32'(MemRead & MemWrite), 32'd0);
      rw_cnt += int'(RegWrite);
    end
    check_eq({name, " regwrite_count"}, 32'(rw_cnt), 32'(exp_rw));
  endtask

  logic [5:0] legal_ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                               6'b000010};
  logic [5:0] functs[8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                            6'b011000, 6'b100110, 6'b100111};

  initial begin
    reset    = 1'b1;
    MemReady = 1'b1;
    Opcode   = 6'b000000;
    Funct    = 6'b000000;
    #12;
    check_eq("reset outs", 32'(outs), 32'd0);
    check_eq("reset state", 32'(State), 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    MemReady = 1'b0;

    // lw with zero-wait memory: 0,1,2,3,4.
    build(6'b100011, 6'b000000, 0, 0);
    check_eq("lw length", 32'(plan.size()), 32'd5);
    run_plan("lw", 6'b100011, 6'b000000, 1);

    // sw with MemReady low 3 cycles in MEMWR.
    build(6'b101011, 6'b000000, 1, 3);
    run_plan("sw_wait", 6'b101011, 6'b000000, 0);

    // nor R-type.
    build(6'b000000, 6'b100111, 0, 0);
    run_plan("rtype_nor", 6'b000000, 6'b100111, 1);

    // mult: stretched RTEXEC only when the stall feature is built in.
    build(6'b000000, 6'b011000, 0, 0);
    run_plan("mult", 6'b000000, 6'b011000, 1);

    // beq, addi, j with zero waits.
    build(6'b000100, 6'b000000, 0, 0);
    run_plan("beq", 6'b000100, 6'b000000, 0);
    build(6'b001000, 6'b000000, 0, 0);
    run_plan("addi", 6'b001000, 6'b000000, 1);
    build(6'b000010, 6'b000000, 0, 0);
    run_plan("j", 6'b000010, 6'b000000, 0);

    // Reset while waiting in MEMRD, then an illegal opcode after release.
    plan.delete();
    add_step(0, 1'b1);
    add_step(1, 1'b0);
    add_step(2, 1'b0);
    add_step(3, 1'b0);
    run_plan("lw_pre_reset", 6'b100011, 6'b000000, 0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("midreset outs", 32'(outs), 32'd0);
    check_eq("midreset state", 32'(State), 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    MemReady = 1'b0;
    build(6'b111111, 6'b000000, 0, 0);
    run_plan("illegal_after_reset", 6'b111111, 6'b000000, 0);

    // Randomized instruction stream with random memory waits.
    for (int k = 0; k < 150; k++) begin
      logic [5:0] op, fn;
      int cls = int'($urandom_range(0, 6));
      int exp_rw;
      if (cls < 6) op = legal_ops[cls];
      else begin
        op = 6'($urandom);
        foreach (legal_ops[j]) if (op == legal_ops[j]) op = 6'b111111;
      end
      fn = ($urandom_range(0, 1) == 1) ? functs[$urandom_range(0, 7)] : 6'($urandom);
      exp_rw = (op == 6'b100011 || op == 6'b000000 || op == 6'b001000) ? 1 : 0;
      build(op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      run_plan($sformatf("rand%0d_op%02h", k, op), op, fn, exp_rw);
    end

    // After the stream, the FSM must be back in FETCH.
    @(posedge clk);
    #1;
    MemReady = 1'b0;
    @(negedge clk);
    check_eq("final state", 32'(State), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
